rx_fifo_wctrl: RTL

- Write-side controller for the PCS RX asynchronous FIFO. Sits directly upstream of fifomem_2 and drives its waddr, wclken and wfull.
- Maintains the binary and Gray write pointers and synchronises the read-domain Gray pointer into wclk.
- Generates full, almost-full, fill level and a sticky overflow flag for 72-bit XGMII-style columns arriving from the RX descrambler/decoder.

---
 rtl/rx_pcs_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/rx_fifo_wctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/rx_pcs_pkg.sv
// rx_pcs_pkg: shared XGMII column constants and pointer helpers for the PCS RX FIFO controllers.
//   Contents: idle/control byte codes, control-field position in a 72-bit column,
//   gray2bin() for converting synchronised Gray pointers back to binary.
package rx_pcs_pkg;

    localparam logic [7:0] XGMII_IDLE_BYTE = 8'h07;
    localparam logic [7:0] XGMII_CTRL_ALL  = 8'hFF;
    localparam int         CTRL_MSB        = 71;
    localparam int         CTRL_LSB        = 64;

    // XOR prefix chain from the MSB down; narrower pointers are passed
    // zero-extended, which leaves their low bits correct.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a Gray-coded pointer crossing into clk.
//   Ports: clk, rst_n (async active-low), d (asynchronous input), q (synchronised output).
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q1_q;
    logic [WIDTH-1:0] q2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1_q <= '0;
            q2_q <= '0;
        end else begin
            q1_q <= d;
            q2_q <= q1_q;
        end
    end

    assign q = q2_q;

endmodule

// File: rtl/rx_fifo_wctrl.sv
// rx_fifo_wctrl: write-side controller of the PCS RX async FIFO (pointers, full/almost-full, level, overflow).
//   Inputs : wclk, wrst_n (async active-low), winc, wdata, rptr (read-domain Gray), wovf_clr.
//   Outputs: waddr, wclken (to fifomem_2), wptr (Gray, to read domain), wfull, walmost_full,
//            wlevel, woverflow; wdrop_cnt when built with RX_IDLE_DELETE_EN (idle-column deletion).
module rx_fifo_wctrl
    import rx_pcs_pkg::*;
#(
    parameter int DATASIZE     = 72,
    parameter int ADDRSIZE     = 7,
    parameter int AFULL_THRESH = 96
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [DATASIZE-1:0] wdata,
    input  logic [ADDRSIZE:0]   rptr,
    input  logic                wovf_clr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic                wclken,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wlevel,
`ifdef RX_IDLE_DELETE_EN
    output logic [15:0]         wdrop_cnt,
`endif
    output logic                woverflow
);

    localparam int               PW     = ADDRSIZE + 1;
    localparam logic [ADDRSIZE:0] AF_LVL = AFULL_THRESH[ADDRSIZE:0];

    logic [ADDRSIZE:0] wq2_rptr;
    logic [ADDRSIZE:0] rbin_s;
    logic              accept;
    logic              drop;
    logic [ADDRSIZE:0] wbin_q, wbin_d;
    logic [ADDRSIZE:0] wptr_q, wptr_d;
    logic [ADDRSIZE:0] wlevel_q, wlevel_d;
    logic              wfull_q, wfull_d;
    logic              walmost_full_q, walmost_full_d;
    logic              woverflow_q, woverflow_d;

    sync_2ff #(.WIDTH(PW)) u_rptr_sync (
        .clk   (wclk),
        .rst_n (wrst_n),
        .d     (rptr),
        .q     (wq2_rptr)
    );

`ifdef RX_IDLE_DELETE_EN
    logic        idle_col;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Only a column that is idle in every lane may be deleted; terminate/start
    // columns carry other control codes and fail the byte compare.
    always_comb begin
        idle_col = wdata[CTRL_MSB:CTRL_LSB] == XGMII_CTRL_ALL;
        for (int k = 0; k < 8; k++) idle_col = idle_col & (wdata[8*k +: 8] == XGMII_IDLE_BYTE);
        drop = winc & idle_col & walmost_full_q & ~wfull_q;
        drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) drop_cnt_q <= '0;
        else         drop_cnt_q <= drop_cnt_d;
    end

    assign wdrop_cnt = drop_cnt_q;
`else
    logic unused_wdata;

    assign drop         = 1'b0;
    assign unused_wdata = ^wdata;
`endif

    // wrst_n in the accept term keeps wclken low for the whole reset window,
    // so no memory write can slip through while the pointers are held at zero.
    always_comb begin
        accept         = wrst_n & winc & ~wfull_q & ~drop;
        wbin_d         = wbin_q + {{ADDRSIZE{1'b0}}, accept};
        wptr_d         = (wbin_d >> 1) ^ wbin_d;
        rbin_s         = PW'(gray2bin(32'(wq2_rptr)));
        wlevel_d       = wbin_d - rbin_s;
        // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
        wfull_d        = wptr_d == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
        walmost_full_d = wlevel_d >= AF_LVL;
        woverflow_d    = (winc & wfull_q) | (woverflow_q & ~wovf_clr);
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_q         <= '0;
            wptr_q         <= '0;
            wlevel_q       <= '0;
            wfull_q        <= 1'b0;
            walmost_full_q <= 1'b0;
            woverflow_q    <= 1'b0;
        end else begin
            wbin_q         <= wbin_d;
            wptr_q         <= wptr_d;
            wlevel_q       <= wlevel_d;
            wfull_q        <= wfull_d;
            walmost_full_q <= walmost_full_d;
            woverflow_q    <= woverflow_d;
        end
    end

    assign waddr        = wbin_q[ADDRSIZE-1:0];
    assign wclken       = accept;
    assign wptr         = wptr_q;
    assign wfull        = wfull_q;
    assign walmost_full = walmost_full_q;
    assign wlevel       = wlevel_q;
    assign woverflow    = woverflow_q;

endmodule
